// File: rtl/bcd7_scan_if.sv
// Display-word and pin bundle between the BCD7 register block and the scan driver.
// master = register/software side, slave = the scan driver.
interface bcd7_scan_if;
    logic [11:0] disp_word;
    logic        raw_mode;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    modport master (output disp_word, raw_mode, input an, seg, frame_tick);
    modport slave  (input disp_word, raw_mode, output an, seg, frame_tick);
endinterface

// File: rtl/bcd7_scan.sv
// 4-digit common-anode 7-segment driver: hex scan of a frame-coherent snapshot
// with leading-zero blanking, or raw pass-through of anode/segment bits.
module bcd7_scan #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic         clk,
    input  logic         reset,
    bcd7_scan_if.slave   bus
);
    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    localparam logic [1:0] IDX_D0 = 2'd0;
    localparam logic [1:0] IDX_D1 = 2'd1;
    localparam logic [1:0] IDX_D2 = 2'd2;
    localparam logic [1:0] IDX_D3 = 2'd3;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   snap_q, snap_d;
    logic          frame_q, frame_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          scan_tick;
    logic [3:0]    nib;
    logic          blank;

    // Hex nibble to active-low g..a pattern.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        scan_tick = (presc_q == PRESC_LAST);
        presc_d   = scan_tick ? '0 : presc_q + 1'b1;
        idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
        frame_d   = scan_tick && (idx_q == IDX_D3);
        snap_d    = frame_d ? bus.disp_word : snap_q;

        // Slot decode works on the snapshot only, so mid-frame writes never tear.
        nib   = 4'h0;
        blank = 1'b1;
        an_d  = 4'hF;
        case (idx_q)
            IDX_D0: begin
                nib   = snap_q[3:0];
                blank = 1'b0;
                an_d  = 4'b1110;
            end
            IDX_D1: begin
                nib   = snap_q[7:4];
                blank = (LZ_BLANK != 0) && (snap_q[11:8] == 4'h0) && (snap_q[7:4] == 4'h0);
                an_d  = 4'b1101;
            end
            IDX_D2: begin
                nib   = snap_q[11:8];
                blank = (LZ_BLANK != 0) && (snap_q[11:8] == 4'h0);
                an_d  = 4'b1011;
            end
            default: begin
                nib   = 4'h0;
                blank = 1'b1;
                an_d  = 4'hF;
            end
        endcase

        seg_d = {1'b1, decode(nib)};
        if (blank) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end

        if (bus.raw_mode) begin
            an_d  = bus.disp_word[11:8];
            seg_d = bus.disp_word[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= IDX_D0;
            snap_q  <= 12'h000;
            frame_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_q;
endmodule

// File: doc/bcd7_scan.md
Name: bcd7_scan

Overview:
- Downstream consumer of the 12-bit display word held by the BCD7 peripheral register.
- Drives the physical 4-digit common-anode 7-segment display pins.
- Hex mode: time-multiplexes the word as three hex digits, with hardware refresh, frame-coherent snapshot and leading-zero blanking.
- Raw mode: passes the software-driven format ([11:8] anodes, [7:0] segments) straight to the pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; legal range 2 to 2^20.
- LZ_BLANK, 1: 1 enables leading-zero blanking in hex mode; 0 always shows all three digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- disp_word  input  12  display word from the BCD7 register output.
- raw_mode  input  1  1 = raw pass-through; 0 = hex scan.
- an  output  4  digit anodes, active low; bit 3 is the leftmost digit.
- seg  output  8  segments, active low; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- frame_tick  output  1  one-cycle pulse when the scan index wraps 3->0.

Behaviour:
- Reset is synchronous: all state is cleared at the first clk edge with reset high.
- Reset values: an=4'hF, seg=8'hFF, frame_tick=0, prescaler=0, digit index=0, snapshot=12'h000.
- Reset asserted mid-scan aborts the scan immediately, with no partial frame.
- Prescaler counts 0..SCAN_DIV-1, then wraps to 0.
  - Scan tick is asserted in the cycle where prescaler == SCAN_DIV-1.
- Digit index (2 bits) advances 0->1->2->3->0 on each scan tick.
- On the tick where the index goes 3->0:
  - snapshot <= disp_word (sampled in that same cycle);
  - frame_tick = 1 for exactly that one cycle, registered, aligned with the index update.
- Prescaler, index and snapshot run continuously in both modes.
- Hex mode (raw_mode=0), per index i, with nibble n_i = snapshot[4i+3:4i]:
  - Index 0, 1, 2: an = 4'b1111 with bit i cleared; seg[6:0] = decode(n_i).
  - Index 3: an = 4'hF and seg = 8'hFF (digit 3 is never lit).
  - seg[7] = 1 always (dp off).
- Leading-zero blanking (LZ_BLANK=1). A blanked slot drives an = 4'hF and seg = 8'hFF.
  - Digit 2 is blanked when n2 == 0.
  - Digit 1 is blanked when n2 == 0 and n1 == 0.
  - Digit 0 is never blanked (value 0 shows a single "0").
- Decode table, seg[6:0] hex, active low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Raw mode (raw_mode=1):
  - an <= disp_word[11:8] and seg <= disp_word[7:0] every cycle, registered, 1-cycle latency.
  - No snapshot and no blanking are applied.
- Latency: an/seg are registered.
  - In hex mode they reflect the index/snapshot value one cycle after it changes.
  - A raw_mode toggle takes effect on the next clk edge; no glitch cycle with more than one anode low is permitted in hex mode.
- Tearing rule: changes to disp_word mid-frame are invisible in hex mode until the next 3->0 wrap.

Test Plan:
- Reset then release, SCAN_DIV=4, disp_word=12'h000, raw_mode=0 -> an/seg = F/FF during reset; frame_tick first at cycle 15 after release; digit 0 then shows an=4'b1110, seg=8'hC0.
- After the first frame_tick, disp_word=12'h3A7, LZ_BLANK=1 -> slots in sequence: an=1110/seg=F8, an=1101/seg=88, an=1011/seg=B0, an=1111/seg=FF; the sequence repeats each 16 cycles.
- disp_word=12'h005 with LZ_BLANK=1 -> only digit 0 lit (seg=92), digits 1/2 dark; the same input with LZ_BLANK=0 -> digits 1 and 2 show seg=C0.
- Change disp_word from 12'h111 to 12'h222 mid-frame -> remaining slots of the current frame still show 1 (seg=F9); 2 (seg=A4) appears only after the next frame_tick.
- raw_mode=1 with disp_word=12'h6A5 -> next cycle an=4'h6, seg=8'hA5, held constant across scan ticks; dropping raw_mode resumes the hex scan at the current index.
- Assert reset for 1 cycle while index=2 -> next cycle an=F, seg=FF, prescaler=0, index=0, snapshot=000.
